mem_arbiter: RTL and testbench

//  Shares one byte-wide synchronous RAM port between the IF-stage fetch port and the MEM-stage load/store port.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM port between the fetch
// (IF) requester and the load/store (MEM) requester. Each access is split
// into consecutive byte transactions, and read bytes are assembled
// little-endian into a zero-extended 32-bit result.
//
// Handshake: a requester raises req with its operands and keeps them until
// its ready output pulses for one cycle. In that cycle the read data is
// valid (loads and fetches), or every byte has been written (stores). The
// requester then drops or replaces req in the following cycle. Operands
// are latched at grant, so any later change to them has no effect.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [31:0]           if_data,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic                  stall_req
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    state_t                state;
    state_t                state_next;

    // Latched copy of the granted request.
    logic                  gnt_mem;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            last_q;
    logic                  we_q;
    logic [31:0]           wdata_q;

    // Cycles since the first byte issue. It is the issue index while in
    // ISSUE. It runs RAM_LAT ahead of the capture index.
    logic [2:0]            cyc;
    logic [31:0]           rdata_q;

    logic                  grant;
    logic [1:0]            req_last;
    logic                  issue_last;
    logic [2:0]            cap_idx;
    logic                  cap_en;
    logic                  cap_last;
    logic [31:0]           rdata_merged;

    assign grant      = (state == IDLE) && (mem_req || if_req);
    assign issue_last = (state == ISSUE) && (cyc[1:0] == last_q);
    assign cap_idx    = cyc - LAT;
    assign cap_en     = ((state == ISSUE) || (state == WAIT)) && !we_q &&
                        (cyc >= LAT) && (cap_idx <= {1'b0, last_q});
    assign cap_last   = cap_en && (cap_idx[1:0] == last_q);
    assign stall_req  = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    // Index of the final byte of the request being granted (MEM wins).
    always_comb begin
        req_last = 2'd3;
        if (mem_req) begin
            case (mem_size)
                2'b00:   req_last = 2'd0;
                2'b01:   req_last = 2'd1;
                default: req_last = 2'd3;
            endcase
        end
    end

    // Read word with the byte arriving this cycle already merged in.
    always_comb begin
        rdata_merged = rdata_q;
        if (cap_en) begin
            rdata_merged[{cap_idx[1:0], 3'b000} +: 8] = ram_rdata;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_req || if_req) state_next = ISSUE;
            ISSUE:   if (issue_last) state_next = we_q ? DONE : WAIT;
            WAIT:    if (cap_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: request latch, byte issue, read assembly and ready pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_mem   <= 1'b0;
            addr_q    <= '0;
            last_q    <= 2'd0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            cyc       <= 3'd0;
            rdata_q   <= 32'd0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'd0;
            if_ready  <= 1'b0;
            if_data   <= 32'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'd0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_mem   <= mem_req;
                        addr_q    <= mem_req ? mem_addr : if_addr;
                        last_q    <= req_last;
                        we_q      <= mem_req & mem_we;
                        wdata_q   <= mem_req ? mem_wdata : 32'd0;
                        cyc       <= 3'd0;
                        rdata_q   <= 32'd0;
                        ram_ce    <= 1'b1;
                        ram_we    <= mem_req & mem_we;
                        ram_addr  <= mem_req ? mem_addr : if_addr;
                        ram_wdata <= (mem_req & mem_we) ? mem_wdata[7:0] : 8'd0;
                    end
                end
                ISSUE, WAIT: begin
                    cyc     <= cyc + 3'd1;
                    rdata_q <= rdata_merged;
                    if ((state == ISSUE) && !issue_last) begin
                        ram_ce    <= 1'b1;
                        ram_we    <= we_q;
                        ram_addr  <= addr_q + ADDR_WIDTH'(cyc) + ADDR_WIDTH'(1);
                        ram_wdata <= we_q ? wdata_q[{cyc[1:0] + 2'd1, 3'b000} +: 8] : 8'd0;
                    end
                    if (state_next == DONE) begin
                        if (gnt_mem) begin
                            mem_ready <= 1'b1;
                            if (!we_q) mem_rdata <= rdata_merged;
                        end else begin
                            if_ready <= 1'b1;
                            if_data  <= rdata_merged;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM_LAT 1 and 3), each with its own
// byte RAM model sharing one backing store, a byte-level reference memory,
// a table of directed vectors, hand-written corner sequences and random
// transactions.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_ready  [2];
    logic [31:0] if_data   [2];
    logic        mem_req   [2];
    logic        mem_we    [2];
    logic [1:0]  mem_size  [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_ready [2];
    logic [31:0] mem_rdata [2];
    logic        ram_ce    [2];
    logic        ram_we    [2];
    logic [31:0] ram_addr  [2];
    logic [7:0]  ram_wdata [2];
    logic [7:0]  ram_rdata [2];
    logic        stall_req [2];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.ADDR_WIDTH(32), .RAM_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_ready  (if_ready[g]),
            .if_data   (if_data[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_size  (mem_size[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_ready (mem_ready[g]),
            .mem_rdata (mem_rdata[g]),
            .ram_ce    (ram_ce[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g]),
            .stall_req (stall_req[g])
        );
    end

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: writes on the edge, read byte presented RAM_LAT cycles after issue.
    logic [7:0]  ram_mem [logic [31:0]];
    logic        rd_v [2][3];
    logic [31:0] rd_a [2][3];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 1 : 3;
            if (ram_ce[d] === 1'b1 && ram_we[d] === 1'b1) ram_mem[ram_addr[d]] = ram_wdata[d];
            for (int s = 2; s > 0; s--) begin
                rd_v[d][s] = rd_v[d][s-1];
                rd_a[d][s] = rd_a[d][s-1];
            end
            rd_v[d][0] = (ram_ce[d] === 1'b1) && (ram_we[d] === 1'b0);
            rd_a[d][0] = ram_addr[d];
            ram_rdata[d] <= (rd_v[d][lat-1] === 1'b1) ? ram_rd(rd_a[d][lat-1]) : 8'hA5;
        end
    end

    // Reference model: flat byte memory, accesses applied byte by byte.
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input bit is_if, input logic [1:0] size);
        if (is_if) return 4;
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model(input bit is_if, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data);
        data = 32'd0;
        for (int k = 0; k < nbytes(is_if, size); k++) begin
            logic [31:0] a;
            a = addr + 32'(k);
            if (we && !is_if) ref_mem[a] = wdata[8*k +: 8];
            else              data[8*k +: 8] = ref_rd(a);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram_mem[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver + monitor for one transaction: request is raised in cycle 0.
    task automatic do_txn(input int d, input bit is_if, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input int exp_cyc);
        int  n;
        int  cyc;
        bit  done;
        bit  wr;
        logic [31:0] ea;
        n  = nbytes(is_if, size);
        wr = we && !is_if;
        @(negedge clk);
        if (is_if) begin
            if_req[d] = 1'b1; if_addr[d] = addr;
        end else begin
            mem_req[d] = 1'b1; mem_we[d] = we; mem_size[d] = size;
            mem_addr[d] = addr; mem_wdata[d] = wdata;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc >= 1 && cyc <= n) begin
                ea = addr + 32'(cyc - 1);
                chk("bus_ce", ram_ce[d], 1'b1);
                chk("bus_addr", ram_addr[d], ea);
                chk("bus_we", ram_we[d], wr);
                if (wr) chk("bus_wdata", ram_wdata[d], wdata[8*(cyc-1) +: 8]);
            end else begin
                chk("bus_idle", {ram_ce[d], ram_we[d], ram_addr[d], ram_wdata[d]}, 42'd0);
            end
            chk("other_ready", is_if ? mem_ready[d] : if_ready[d], 1'b0);
            if ((is_if ? if_ready[d] : mem_ready[d]) === 1'b1) begin
                done = 1'b1;
                chk("ready_cycle", cyc, exp_cyc);
                if (!wr) chk("rdata", is_if ? if_data[d] : mem_rdata[d], exp_data);
                chk("stall_at_ready", stall_req[d], 1'b0);
            end else begin
                chk("stall_busy", stall_req[d], 1'b1);
            end
            if (cyc == 2) begin
                if_addr[d]   = $urandom;
                mem_addr[d]  = $urandom;
                mem_wdata[d] = $urandom;
                mem_size[d]  = 2'($urandom_range(0, 3));
                mem_we[d]    = 1'($urandom_range(0, 1));
            end
        end
        chk("ready_seen", done, 1'b1);
        if_req[d]  = 1'b0;
        mem_req[d] = 1'b0;
        mem_we[d]  = 1'b0;
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] expd;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if_req[d] = 0; if_addr[d] = 0; mem_req[d] = 0; mem_we[d] = 0;
            mem_size[d] = 0; mem_addr[d] = 0; mem_wdata[d] = 0;
        end
        vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'h0010_0513, 6};
        vecs[1] = '{1'b0, 1'b1, 2'b01, 32'h0000_3001, 32'h0000_BEEF, 32'h0,         3};
        vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h0000_3001, 32'h0,         32'h0000_BEEF, 4};
        vecs[3] = '{1'b0, 1'b0, 2'b00, 32'h0000_0040, 32'h0,         32'h0000_0080, 3};
        vecs[4] = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'h4433_2211, 6};
        vecs[5] = '{1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'h0,         32'h0010_0513, 6};
        vecs[6] = '{1'b0, 1'b1, 2'b00, 32'h0000_0041, 32'hFFFF_FF5A, 32'h0,         2};
        vecs[7] = '{1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0,         32'h0000_5A80, 6};
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        preload(32'h40, 8'h80);
        preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h22);
        preload(32'h0, 8'h33); preload(32'h1, 8'h44);
        preload(32'h2000, 8'hEF); preload(32'h2001, 8'hBE);
        preload(32'h2002, 8'hAD); preload(32'h2003, 8'hDE);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ram", {ram_ce[d], ram_we[d], ram_addr[d], ram_wdata[d]}, 42'd0);
            chk("reset_ready", {if_ready[d], mem_ready[d]}, 2'b00);
            chk("reset_if_data", if_data[d], 32'd0);
            chk("reset_mem_rdata", mem_rdata[d], 32'd0);
        end
        rst = 1'b1;

        // Directed vectors on the RAM_LAT=1 instance.
        for (int i = 0; i < 8; i++) begin
            model(vecs[i].is_if, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, expd);
            do_txn(0, vecs[i].is_if, vecs[i].we, vecs[i].size, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_cyc);
        end

        // Word fetch on the RAM_LAT=3 instance.
        do_txn(1, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 32'h0010_0513, 8);

        // Simultaneous requests: MEM first, IF resampled after DONE.
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 32'h0;
        mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_size[0] = 2'b10; mem_addr[0] = 32'h2000;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("prio_mem_ready", mem_ready[0], c == 6);
            chk("prio_if_ready", if_ready[0], c == 13);
            chk("prio_stall", stall_req[0], c < 13);
            chk("prio_ce", ram_ce[0], (c >= 1 && c <= 4) || (c >= 8 && c <= 11));
            if (c >= 1 && c <= 4) chk("prio_mem_addr", ram_addr[0], 32'h2000 + 32'(c - 1));
            if (c >= 8 && c <= 11) chk("prio_if_addr", ram_addr[0], 32'(c - 8));
            if (c == 2) begin mem_addr[0] = 32'hDEAD_0000; mem_size[0] = 2'b00; end
            if (c == 6) begin chk("prio_mem_rdata", mem_rdata[0], 32'hDEAD_BEEF); mem_req[0] = 1'b0; end
            if (c == 13) begin chk("prio_if_data", if_data[0], 32'h0000_4433); if_req[0] = 1'b0; end
        end

        // Request dropped mid-transfer still completes once.
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 32'h100;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("drop_if_ready", if_ready[0], c == 6);
            chk("drop_ce", ram_ce[0], c >= 1 && c <= 4);
            if (c == 6) chk("drop_if_data", if_data[0], 32'h0010_0513);
            if (c == 2) if_req[0] = 1'b0;
        end

        // Random traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            int          d;
            bit          is_if;
            bit          we;
            logic [1:0]  size;
            logic [31:0] addr;
            logic [31:0] wdata;
            int          ecyc;
            d     = (i % 4 == 3) ? 1 : 0;
            is_if = ($urandom_range(0, 3) == 0);
            we    = !is_if && ($urandom_range(0, 1) == 1);
            size  = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                               : 32'h500 + 32'($urandom_range(0, 15));
            wdata = $urandom;
            model(is_if, we, size, addr, wdata, expd);
            ecyc = nbytes(is_if, size) + 1 + (we ? 0 : ((d == 0) ? 1 : 3));
            do_txn(d, is_if, we, size, addr, wdata, expd, ecyc);
        end

        // Reset in cycle 3 of a word store.
        @(negedge clk);
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_size[0] = 2'b10;
        mem_addr[0] = 32'h600; mem_wdata[0] = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pre_addr", ram_addr[0], 32'h602);
        rst = 1'b0;
        #1;
        chk("rst_ram", {ram_ce[0], ram_we[0], ram_addr[0], ram_wdata[0]}, 42'd0);
        chk("rst_ready", {if_ready[0], mem_ready[0]}, 2'b00);
        chk("rst_if_data", if_data[0], 32'd0);
        chk("rst_mem_rdata", mem_rdata[0], 32'd0);
        mem_req[0] = 1'b0; mem_we[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // Bytes issued in cycles 1 and 2 reached the RAM before reset.
        ref_mem[32'h600] = 8'h0D;
        ref_mem[32'h601] = 8'hF0;
        do_txn(0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 32'h0010_0513, 6);
        model(1'b0, 1'b0, 2'b10, 32'h600, 32'h0, expd);
        do_txn(0, 1'b0, 1'b0, 2'b10, 32'h600, 32'h0, expd, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
